fifo_read_streamer: RTL and testbench

- Read-side consumer for the FIFO, in the clk_r domain.
- On a start pulse, pops a burst of burst_len words by driving rd_en against buf_empty.
- Captures buf_out and presents the words on a valid/ready stream with out_last marking the final word.
- A 2-entry internal skid buffer absorbs the one-cycle FIFO read latency, so downstream backpressure never drops data.

---
 rtl/fifo_read_streamer.sv | 148 ++++++++++++++
 tb/tb_fifo_read_streamer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_streamer.sv
// Read-side FIFO consumer: pops a burst of words and streams them out on a
// valid/ready interface through a 2-entry skid buffer covering the FIFO read latency.
module fifo_read_streamer #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk_r,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              buf_empty,
  input  logic [DATA_W-1:0] buf_out,
  output logic              rd_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t             state_r;
  state_t             state_s;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   issued_r;
  logic [LEN_W-1:0]   delivered_r;
  logic [LEN_W-1:0]   last_idx_s;
  logic               inflight_r;
  logic [1:0]         occ_r;
  logic [DATA_W-1:0]  skid_r [2];
  logic               handshake_s;
  logic [2:0]         credit_used_s;

  assign handshake_s = out_valid && out_ready;
  assign last_idx_s  = len_r - LEN_ONE;

  // Credit counts the skid slot being freed by this cycle's handshake, so a
  // ready consumer sustains one word per cycle while occupancy never exceeds 2.
  assign credit_used_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, handshake_s};
  assign rd_en = (state_r == RUN) && !buf_empty && (issued_r < len_r) && (credit_used_s < 3'd2);

  assign out_valid = (occ_r != 2'd0);
  assign out_data  = skid_r[0];
  assign out_last  = out_valid && (delivered_r == last_idx_s);
  assign busy      = (state_r == RUN) || (state_r == DRAIN);
  assign done      = (state_r == DONE);

  // Next-state logic of the burst controller.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = (burst_len != {LEN_W{1'b0}}) ? RUN : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (rd_en && (issued_r == last_idx_s)) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (handshake_s && (delivered_r == last_idx_s)) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register, burst length and issue/delivery counters.
  always_ff @(posedge clk_r) begin
    if (rst) begin
      state_r     <= IDLE;
      len_r       <= {LEN_W{1'b0}};
      issued_r    <= {LEN_W{1'b0}};
      delivered_r <= {LEN_W{1'b0}};
      inflight_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      inflight_r <= rd_en;
      if ((state_r == IDLE) && start) begin
        len_r       <= burst_len;
        issued_r    <= {LEN_W{1'b0}};
        delivered_r <= {LEN_W{1'b0}};
      end else begin
        if (rd_en) begin
          issued_r <= issued_r + LEN_ONE;
        end
        if (handshake_s) begin
          delivered_r <= delivered_r + LEN_ONE;
        end
      end
    end
  end

  // Skid buffer: push the word returned by the FIFO, pop the head on handshake.
  always_ff @(posedge clk_r) begin
    if (rst) begin
      occ_r     <= 2'd0;
      skid_r[0] <= {DATA_W{1'b0}};
      skid_r[1] <= {DATA_W{1'b0}};
    end else begin
      case ({inflight_r, handshake_s})
        2'b10: begin
          if (occ_r == 2'd0) begin
            skid_r[0] <= buf_out;
          end else begin
            skid_r[1] <= buf_out;
          end
          occ_r <= occ_r + 2'd1;
        end
        2'b01: begin
          skid_r[0] <= skid_r[1];
          occ_r     <= occ_r - 2'd1;
        end
        2'b11: begin
          if (occ_r == 2'd1) begin
            skid_r[0] <= buf_out;
          end else begin
            skid_r[0] <= skid_r[1];
            skid_r[1] <= buf_out;
          end
        end
        default: begin
          occ_r <= occ_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Directed testbench for fifo_read_streamer with a registered-read FIFO model
// and a negedge monitor recording handshakes, pops and done pulses.
module tb_fifo_read_streamer;
  localparam int DW = 8;
  localparam int LW = 4;

  logic          clk_r = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = 4'd0;
  logic          buf_empty;
  logic [DW-1:0] buf_out = 8'd0;
  logic          rd_en;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_read_streamer #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk_r(clk_r), .rst(rst), .start(start), .burst_len(burst_len),
    .buf_empty(buf_empty), .buf_out(buf_out), .rd_en(rd_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk_r = ~clk_r;

  // FIFO model: data appears on buf_out the cycle after rd_en
  logic [DW-1:0] mem [0:255];
  int wptr = 0;
  int rptr = 0;
  assign buf_empty = (wptr == rptr);
  always @(posedge clk_r) begin
    if (rd_en && !buf_empty) begin
      buf_out <= mem[rptr[7:0]];
      rptr    <= rptr + 1;
    end
  end

  // Monitor, sampled on the falling edge
  logic clr = 1'b0;
  int cyc, rd_cnt, hs_cnt, rd_empty_viol, max_out, hold_viol, done_cnt;
  int done_cyc, st_cyc, rd_first, rd_last;
  logic busy_at_done, busy_at_last_hs, prev_stall;
  logic [DW-1:0] prev_data;
  logic [DW-1:0] got[$];
  logic lastf[$];
  int hs_cyc[$];

  always @(negedge clk_r) begin
    if (clr) begin
      cyc = 0; rd_cnt = 0; hs_cnt = 0; rd_empty_viol = 0; max_out = 0;
      hold_viol = 0; done_cnt = 0; done_cyc = -1; st_cyc = -1;
      rd_first = -1; rd_last = -1; prev_stall = 1'b0;
      busy_at_done = 1'b1; busy_at_last_hs = 1'b0;
      got.delete(); lastf.delete(); hs_cyc.delete();
    end else begin
      if (rd_cnt - hs_cnt > max_out) max_out = rd_cnt - hs_cnt;
      if (start && st_cyc < 0) st_cyc = cyc;
      if (prev_stall && (!out_valid || out_data !== prev_data)) hold_viol++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (rd_en) begin
        if (buf_empty) rd_empty_viol++;
        if (rd_first < 0) rd_first = cyc;
        rd_last = cyc;
        rd_cnt++;
      end
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        lastf.push_back(out_last);
        hs_cyc.push_back(cyc);
        busy_at_last_hs = busy;
        hs_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
      cyc++;
    end
  end

  task automatic tick;
    @(posedge clk_r);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] v);
    mem[wptr[7:0]] = v;
    wptr = wptr + 1;
  endtask

  task automatic clear_stats;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0 repeating
  task automatic run_burst(input logic [LW-1:0] len, input int mode, input bit repulse,
                           input bit late_push, output bit timed_out);
    int k;
    start = 1'b1;
    burst_len = len;
    tick();
    start = 1'b0;
    k = 0;
    while (done_cnt == 0 && k < 300) begin
      out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      if (repulse && k == 3) begin
        start = 1'b1;
        burst_len = 4'd2;
      end else begin
        start = 1'b0;
      end
      if (late_push && k == 20) begin
        push(8'h43); push(8'h44); push(8'h45);
      end
      tick();
      k++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    timed_out = (done_cnt == 0);
    tick();
  endtask

  task automatic test_reset;
    push(8'hE1); push(8'hE2); push(8'hE3);
    rst = 1'b1;
    tick(); tick();
    n_tests++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b exp 0", rd_en); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", done); end
    n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h exp 00", out_data); end
    rst = 1'b0;
    tick(); tick();
    n_tests++; if (wptr - rptr !== 3) begin n_fail++; $display("FAIL reset_fifo_untouched: got %0d exp 3", wptr - rptr); end
    wptr = rptr;
  endtask

  task automatic test_basic_burst;
    bit to;
    for (int i = 1; i <= 8; i++) push(8'(i));
    clear_stats();
    run_burst(4'd8, 0, 1'b0, 1'b0, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL basic_timeout: got no done exp done"); end
    n_tests++; if (rd_cnt !== 8) begin n_fail++; $display("FAIL basic_rd_count: got %0d exp 8", rd_cnt); end
    n_tests++; if (rd_last - rd_first !== 7) begin n_fail++; $display("FAIL basic_rd_consecutive: got span %0d exp 7", rd_last - rd_first); end
    n_tests++; if (got.size() !== 8) begin n_fail++; $display("FAIL basic_count: got %0d exp 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      n_tests++; if (got[i] !== 8'(i + 1)) begin n_fail++; $display("FAIL basic_data[%0d]: got %h exp %h", i, got[i], 8'(i + 1)); end
      n_tests++; if (lastf[i] !== (i == 7)) begin n_fail++; $display("FAIL basic_last[%0d]: got %b exp %b", i, lastf[i], (i == 7)); end
    end
    if (hs_cyc.size() == 8) begin
      n_tests++; if (hs_cyc[7] - hs_cyc[0] !== 7) begin n_fail++; $display("FAIL basic_out_consecutive: got span %0d exp 7", hs_cyc[7] - hs_cyc[0]); end
      n_tests++; if (done_cyc !== hs_cyc[7] + 1) begin n_fail++; $display("FAIL basic_done_timing: got %0d exp %0d", done_cyc, hs_cyc[7] + 1); end
    end
    n_tests++; if (busy_at_last_hs !== 1'b1) begin n_fail++; $display("FAIL basic_busy_last: got %b exp 1", busy_at_last_hs); end
    n_tests++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b exp 0", busy_at_done); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d exp 1", done_cnt); end
  endtask

  task automatic test_backpressure;
    bit to;
    for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
    clear_stats();
    run_burst(4'd6, 1, 1'b0, 1'b0, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL bp_timeout: got no done exp done"); end
    n_tests++; if (got.size() !== 6) begin n_fail++; $display("FAIL bp_count: got %0d exp 6", got.size()); end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      n_tests++; if (got[i] !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL bp_data[%0d]: got %h exp %h", i, got[i], 8'h10 + 8'(i)); end
    end
    n_tests++; if (hold_viol !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d violations exp 0", hold_viol); end
    n_tests++; if (max_out > 2) begin n_fail++; $display("FAIL bp_credit: got max %0d exp <=2", max_out); end
    n_tests++; if (lastf.size() == 6 && lastf[5] !== 1'b1) begin n_fail++; $display("FAIL bp_last: got %b exp 1", lastf[5]); end
  endtask

  task automatic test_empty_stall;
    bit to;
    push(8'h41); push(8'h42);
    clear_stats();
    run_burst(4'd5, 0, 1'b0, 1'b1, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL stall_timeout: got no done exp done"); end
    n_tests++; if (rd_empty_viol !== 0) begin n_fail++; $display("FAIL stall_rd_on_empty: got %0d exp 0", rd_empty_viol); end
    n_tests++; if (got.size() !== 5) begin n_fail++; $display("FAIL stall_count: got %0d exp 5", got.size()); end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      n_tests++; if (got[i] !== 8'h41 + 8'(i)) begin n_fail++; $display("FAIL stall_data[%0d]: got %h exp %h", i, got[i], 8'h41 + 8'(i)); end
    end
    if (hs_cyc.size() == 5) begin
      n_tests++; if (hs_cyc[2] - hs_cyc[1] <= 10) begin n_fail++; $display("FAIL stall_pause: got gap %0d exp >10", hs_cyc[2] - hs_cyc[1]); end
      n_tests++; if (done_cyc !== hs_cyc[4] + 1) begin n_fail++; $display("FAIL stall_done_timing: got %0d exp %0d", done_cyc, hs_cyc[4] + 1); end
    end
  endtask

  task automatic test_edge_lengths;
    bit to;
    clear_stats();
    run_burst(4'd0, 0, 1'b0, 1'b0, to);
    tick(); tick();
    n_tests++; if (to) begin n_fail++; $display("FAIL len0_timeout: got no done exp done"); end
    n_tests++; if (done_cyc !== st_cyc + 1) begin n_fail++; $display("FAIL len0_done_timing: got %0d exp %0d", done_cyc, st_cyc + 1); end
    n_tests++; if (rd_cnt !== 0) begin n_fail++; $display("FAIL len0_no_reads: got %0d exp 0", rd_cnt); end
    n_tests++; if (got.size() !== 0) begin n_fail++; $display("FAIL len0_no_words: got %0d exp 0", got.size()); end

    for (int i = 0; i < 15; i++) push(8'hA0 + 8'(i));
    clear_stats();
    run_burst(4'd15, 0, 1'b1, 1'b0, to);
    tick(); tick(); tick();
    n_tests++; if (to) begin n_fail++; $display("FAIL len15_timeout: got no done exp done"); end
    n_tests++; if (got.size() !== 15) begin n_fail++; $display("FAIL len15_count: got %0d exp 15", got.size()); end
    for (int i = 0; i < got.size() && i < 15; i++) begin
      n_tests++; if (got[i] !== 8'hA0 + 8'(i)) begin n_fail++; $display("FAIL len15_data[%0d]: got %h exp %h", i, got[i], 8'hA0 + 8'(i)); end
      n_tests++; if (lastf[i] !== (i == 14)) begin n_fail++; $display("FAIL len15_last[%0d]: got %b exp %b", i, lastf[i], (i == 14)); end
    end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL repulse_done_count: got %0d exp 1", done_cnt); end
    n_tests++; if (rd_cnt !== 15) begin n_fail++; $display("FAIL repulse_rd_count: got %0d exp 15", rd_cnt); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL repulse_idle_after: got busy %b exp 0", busy); end
  endtask

  task automatic test_reset_mid;
    bit to;
    push(8'h71); push(8'h72);
    clear_stats();
    out_ready = 1'b0;
    start = 1'b1;
    burst_len = 4'd2;
    tick();
    start = 1'b0;
    repeat (6) tick();
    n_tests++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_pre_state: got valid %b busy %b exp 1 1", out_valid, busy); end
    n_tests++; if (max_out !== 2) begin n_fail++; $display("FAIL mid_buffered: got %0d exp 2", max_out); end
    rst = 1'b1;
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid_cleared: got %b exp 0", out_valid); end
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got busy %b done %b exp 0 0", busy, done); end
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    n_tests++; if (done_cnt !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d exp 0", done_cnt); end
    wptr = rptr;
    push(8'h5A);
    clear_stats();
    run_burst(4'd1, 0, 1'b0, 1'b0, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL mid_fresh_timeout: got no done exp done"); end
    n_tests++; if (got.size() !== 1 || got[0] !== 8'h5A) begin n_fail++; $display("FAIL mid_fresh_data: got size %0d exp 1 word 5a", got.size()); end
    n_tests++; if (lastf.size() !== 1 || lastf[0] !== 1'b1) begin n_fail++; $display("FAIL mid_fresh_last: got size %0d exp last on word 1", lastf.size()); end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_backpressure();
    test_empty_stall();
    test_edge_lengths();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
